// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART block transmit controller: FSM encoding,
// header byte and gap-counter width.
package uart_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd2;
  localparam logic [2:0] ST_GAP       = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    SEND      = ST_SEND,
    WAIT_DONE = ST_WAIT_DONE,
    GAP       = ST_GAP,
    FINISH    = ST_FINISH
  } state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Wide enough for GAP_CYCLES up to 1023.
  localparam int GAP_W = 10;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: one-clock pulse when d goes 0->1 relative to its
// registered previous value.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/uart_tx_block_ctrl.sv
// Feeds a multi-byte block to a byte-wide UART transmitter, one strobe per
// byte. Define UART_TX_HEADER_EN to prefix every block with header byte 0xA5.
module uart_tx_block_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_BYTES  = 16,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   Blk_Valid_in,
  input  logic [8*NUM_BYTES-1:0] Blk_Data_in,
  output logic                   Blk_Ready_out,
  input  logic                   Tx_Active_in,
  input  logic                   Tx_Done_in,
  output logic                   Tx_DV_out,
  output logic [7:0]             Tx_Byte_out,
  output logic                   Busy_out,
  output logic                   Blk_Done_out
);

  localparam int IDX_W  = $clog2(NUM_BYTES);
  localparam int DATA_W = 8*NUM_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES-1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES-1 : 0);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  blk_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   pos;
  logic [GAP_W-1:0]   gap_q;
  logic [7:0]         byte_q;
  logic [7:0]         pay_byte;
  logic [7:0]         cur_byte;
  logic               done_rise;
  logic               accept;
  logic               strobe;
  logic               byte_done;
  logic               last_byte;

  // Only a fresh Done edge counts, so a two-clock Done completes one byte.
  edge_detect_rise u_done_edge (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (Tx_Done_in),
    .rise  (done_rise)
  );

  assign pos = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;

  always_comb begin
    pay_byte = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++)
      if (pos == IDX_W'(k)) pay_byte = blk_q[8*k +: 8];
  end

`ifdef UART_TX_HEADER_EN
  logic hdr_q;
  assign cur_byte  = hdr_q ? HEADER_BYTE : pay_byte;
  assign last_byte = !hdr_q && (idx_q == LAST_IDX);
`else
  assign cur_byte  = pay_byte;
  assign last_byte = (idx_q == LAST_IDX);
`endif

  assign accept      = Blk_Valid_in && (state_q == IDLE);
  assign Tx_Byte_out = strobe ? cur_byte : byte_q;

  always_comb begin
    state_d       = state_q;
    strobe        = 1'b0;
    byte_done     = 1'b0;
    Tx_DV_out     = 1'b0;
    Blk_Ready_out = (state_q == IDLE);
    Busy_out      = (state_q != IDLE);
    Blk_Done_out  = (state_q == FINISH);
    case (state_q)
      IDLE:      if (Blk_Valid_in) state_d = SEND;
      SEND: begin
        if (!Tx_Active_in && !Tx_Done_in) begin
          strobe    = 1'b1;
          Tx_DV_out = 1'b1;
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          byte_done = 1'b1;
          if (last_byte)           state_d = FINISH;
          else if (GAP_CYCLES > 0) state_d = GAP;
          else                     state_d = SEND;
        end
      end
      GAP:       if (gap_q == GAP_LAST) state_d = SEND;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      blk_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      byte_q  <= 8'h00;
`ifdef UART_TX_HEADER_EN
      hdr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        blk_q <= Blk_Data_in;
        idx_q <= '0;
`ifdef UART_TX_HEADER_EN
        hdr_q <= 1'b1;
`endif
      end
      if (strobe) byte_q <= cur_byte;
      if (byte_done && !last_byte) begin
`ifdef UART_TX_HEADER_EN
        if (hdr_q) hdr_q <= 1'b0;
        else       idx_q <= idx_q + IDX_W'(1);
`else
        idx_q <= idx_q + IDX_W'(1);
`endif
      end
      if (state_q == GAP) gap_q <= (gap_q == GAP_LAST) ? '0 : gap_q + GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_block_ctrl.sv
// Scoreboard bench: two controllers (MSB-first/no gap, LSB-first/5-clock gap)
// each driving a simple transmitter model.
module tb_uart_tx_block_ctrl;

  localparam int NB   = 16;
  localparam int BUSY = 20;
`ifdef UART_TX_HEADER_EN
  localparam int SPB = NB + 1;
`else
  localparam int SPB = NB;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]      blk_valid = 2'b00;
  logic [1:0]      blk_ready, tx_dv, busy, blk_done;
  logic [1:0]      tx_active = 2'b00;
  logic [1:0]      tx_done   = 2'b00;
  logic [NB*8-1:0] blk_data [2];
  logic [7:0]      tx_byte [2];

  int cnt [2]      = '{0, 0};
  int dcnt [2]     = '{0, 0};
  int done_len [2] = '{1, 1};

  uart_tx_block_ctrl #(.NUM_BYTES(NB), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .Blk_Valid_in(blk_valid[0]), .Blk_Data_in(blk_data[0]),
    .Blk_Ready_out(blk_ready[0]), .Tx_Active_in(tx_active[0]), .Tx_Done_in(tx_done[0]),
    .Tx_DV_out(tx_dv[0]), .Tx_Byte_out(tx_byte[0]), .Busy_out(busy[0]), .Blk_Done_out(blk_done[0]));

  uart_tx_block_ctrl #(.NUM_BYTES(NB), .MSB_FIRST(0), .GAP_CYCLES(5)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .Blk_Valid_in(blk_valid[1]), .Blk_Data_in(blk_data[1]),
    .Blk_Ready_out(blk_ready[1]), .Tx_Active_in(tx_active[1]), .Tx_Done_in(tx_done[1]),
    .Tx_DV_out(tx_dv[1]), .Tx_Byte_out(tx_byte[1]), .Busy_out(busy[1]), .Blk_Done_out(blk_done[1]));

  // Transmitter model: busy for BUSY+1 clocks, then Done for done_len clocks.
  // Not reset by RST_N, so a byte in flight completes across a controller reset.
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_dv[i] && !tx_active[i]) begin
        tx_active[i] <= 1'b1;
        cnt[i]       <= BUSY;
      end else if (tx_active[i]) begin
        if (cnt[i] == 0) begin
          tx_active[i] <= 1'b0;
          tx_done[i]   <= 1'b1;
          dcnt[i]      <= done_len[i] - 1;
        end else cnt[i] <= cnt[i] - 1;
      end else if (tx_done[i]) begin
        if (dcnt[i] == 0) tx_done[i] <= 1'b0;
        else              dcnt[i]    <= dcnt[i] - 1;
      end
    end
  end

  logic [8:0] exp_q [2][$];
  int  checks = 0, errors = 0;
  int  strobes [2] = '{0, 0};
  int  dones [2]   = '{0, 0};
  int  gap_cnt [2] = '{0, 0};
  logic [1:0] done_prev = 2'b00;
  logic [1:0] first_in_blk = 2'b00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input int i, input string name, input logic [8:0] act);
    logic [8:0] e;
    chk({name, "_queue_nonempty"}, int'(exp_q[i].size() != 0), 1);
    if (exp_q[i].size() != 0) begin
      e = exp_q[i].pop_front();
      chk(name, int'(act), int'(e));
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        gap_cnt[i]++;
        if (tx_done[i] && !done_prev[i]) gap_cnt[i] = 0;
        done_prev[i] = tx_done[i];
        if (tx_dv[i]) begin
          strobes[i]++;
          if (i == 1 && !first_in_blk[1]) chk("gap_clocks_ge6", int'(gap_cnt[1] >= 6), 1);
          first_in_blk[i] = 1'b0;
          pop_chk(i, i == 0 ? "byte_a" : "byte_b", {1'b0, tx_byte[i]});
        end
        if (blk_done[i]) begin
          dones[i]++;
          pop_chk(i, i == 0 ? "blk_done_a" : "blk_done_b", 9'h100);
        end
      end
    end
  endtask

  task automatic push_hdr(input int i);
`ifdef UART_TX_HEADER_EN
    exp_q[i].push_back(9'h0A5);
`else
    if (i < 0) exp_q[i].push_back(9'h0A5);
`endif
  endtask

  task automatic offer(input int i, input logic [NB*8-1:0] d);
    @(negedge CLK);
    chk("ready_before_offer", int'(blk_ready[i]), 1);
    blk_valid[i]    = 1'b1;
    blk_data[i]     = d;
    first_in_blk[i] = 1'b1;
    @(negedge CLK);
    blk_valid[i] = 1'b0;
    blk_data[i]  = ~d;
  endtask

  task automatic wait_blocks(input int i, input int target);
    int n = 0;
    while (dones[i] < target && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("blk_done_within_budget", int'(dones[i] >= target), 1);
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_dv",    int'(tx_dv[i]), 0);
    chk("rst_byte",  int'(tx_byte[i]), 0);
    chk("rst_ready", int'(blk_ready[i]), 1);
    chk("rst_busy",  int'(busy[i]), 0);
    chk("rst_done",  int'(blk_done[i]), 0);
  endtask

  initial begin
    logic [NB*8-1:0] d;
    int n;
    blk_data[0] = '0;
    blk_data[1] = '0;
    fork
      monitor();
    join_none

    #12;
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(negedge CLK);
    RST_N = 1'b1;

    // Ascending-byte block on both controllers: MSB-first and LSB-first.
    d = 128'h00112233445566778899AABBCCDDEEFF;
    push_hdr(0);
    push_hdr(1);
    for (int k = 0; k < NB; k++) begin
      exp_q[0].push_back({1'b0, 8'(k * 17)});
      exp_q[1].push_back({1'b0, 8'(255 - k * 17)});
    end
    exp_q[0].push_back(9'h100);
    exp_q[1].push_back(9'h100);
    offer(0, d);
    offer(1, d);

    // Offer a different block to the gapped controller mid-block; it must be ignored.
    repeat (100) @(negedge CLK);
    chk("ready_mid_block", int'(blk_ready[1]), 0);
    chk("busy_mid_block",  int'(busy[1]), 1);
    blk_valid[1] = 1'b1;
    blk_data[1]  = {NB{8'h5A}};
    repeat (3) @(negedge CLK);
    blk_valid[1] = 1'b0;
    wait_blocks(0, 1);
    wait_blocks(1, 1);
    chk("strobes_a_blk1", strobes[0], SPB);
    chk("strobes_b_blk1", strobes[1], SPB);

    // Two-clock Done per byte: each byte still counts once.
    done_len[0] = 2;
    push_hdr(0);
    for (int k = 0; k < NB; k++) begin
      d[8*(NB-1-k) +: 8] = 8'(8'hC0 ^ (k * 7));
      exp_q[0].push_back({1'b0, 8'(8'hC0 ^ (k * 7))});
    end
    exp_q[0].push_back(9'h100);
    offer(0, d);
    wait_blocks(0, 2);
    chk("strobes_a_done2", strobes[0], 2 * SPB);
    done_len[0] = 1;

    // Reset while byte 7 is in flight.
    push_hdr(0);
    for (int k = 0; k < NB; k++) begin
      d[8*(NB-1-k) +: 8] = 8'(k + 8'h40);
      exp_q[0].push_back({1'b0, 8'(k + 8'h40)});
    end
    exp_q[0].push_back(9'h100);
    offer(0, d);
    n = 0;
    while (strobes[0] < 2 * SPB + (SPB - NB) + 8 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("reached_byte7", int'(n < 3000), 1);
    repeat (5) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk_reset_vals(0);
    exp_q[0].delete();
    @(negedge CLK);
    chk_reset_vals(0);
    RST_N = 1'b1;

    push_hdr(0);
    for (int k = 0; k < NB; k++) begin
      d[8*(NB-1-k) +: 8] = 8'(8'hF0 - k);
      exp_q[0].push_back({1'b0, 8'(8'hF0 - k)});
    end
    exp_q[0].push_back(9'h100);
    offer(0, d);
    wait_blocks(0, 3);
    repeat (5) @(negedge CLK);

    chk("dones_a", dones[0], 3);
    chk("dones_b", dones[1], 1);
    chk("queue_a_drained", exp_q[0].size(), 0);
    chk("queue_b_drained", exp_q[1].size(), 0);
    chk("idle_ready_a", int'(blk_ready[0]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_block_ctrl.md
UART_TX_BLOCK_CTRL -- requirements
Module: uart_tx_block_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 16, meaning bytes per block (range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning byte order: 1 sends bits [8*NUM_BYTES-1 -: 8] first, 0 sends bits [7:0] first.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 0, meaning idle clocks inserted between consecutive bytes (range 0..1023).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port Blk_Valid_in, input, 1 bit: block offer.
REQ-007 The block SHALL have port Blk_Data_in, input, 8*NUM_BYTES bits: block payload (AES state/ciphertext).
REQ-008 The block SHALL have port Blk_Ready_out, output, 1 bit: block can be accepted.
REQ-009 The block SHALL have port Tx_Active_in, input, 1 bit: UART transmitter busy.
REQ-010 The block SHALL have port Tx_Done_in, input, 1 bit: UART transmitter done (may stay high for 2 consecutive clocks).
REQ-011 The block SHALL have port Tx_DV_out, output, 1 bit: byte-valid strobe to the transmitter.
REQ-012 The block SHALL have port Tx_Byte_out, output, 8 bits: byte to the transmitter.
REQ-013 The block SHALL have port Busy_out, output, 1 bit: a block is in progress.
REQ-014 The block SHALL have port Blk_Done_out, output, 1 bit: one-clock pulse after the last byte completes.

Function
REQ-015 The FSM SHALL have the states IDLE, SEND, WAIT_DONE, GAP and FINISH.
REQ-016 Blk_Ready_out SHALL be 1 only in IDLE; a block is accepted when Blk_Valid_in and Blk_Ready_out are both 1 in the same clock, and it is registered whole; the FSM then goes to SEND and the byte index is cleared to 0.
REQ-017 In SEND, Tx_DV_out SHALL pulse for exactly one clock, with the current byte on Tx_Byte_out, only in a clock where Tx_Active_in==0 and Tx_Done_in==0; otherwise the FSM stays in SEND with Tx_DV_out=0.
REQ-018 After the strobe, the FSM SHALL enter WAIT_DONE and count one byte complete only on the rising edge of Tx_Done_in (registered previous value); a 2-clock-high Done counts once.
REQ-019 On completion, if index==NUM_BYTES-1 the FSM SHALL go to FINISH; otherwise it increments the index and goes to GAP (GAP_CYCLES>0) or straight to SEND (GAP_CYCLES==0).
REQ-020 GAP SHALL last exactly GAP_CYCLES clocks, counted from 0 to GAP_CYCLES-1, and then go to SEND.
REQ-021 FINISH SHALL assert Blk_Done_out for one clock and then return to IDLE.
REQ-022 Busy_out SHALL be 1 in every state except IDLE.
REQ-023 Blk_Valid_in SHALL be ignored while not in IDLE, and Blk_Data_in changes after acceptance SHALL NOT affect the bytes sent.
REQ-024 The byte index SHALL be $clog2(NUM_BYTES) bits wide, SHALL never wrap within a block, and SHALL reset to 0 on every accept.
REQ-025 Tx_Byte_out SHALL hold its last value when Tx_DV_out=0.

Reset
REQ-026 Asserting RST_N low at any time, including mid-byte, SHALL immediately force: state IDLE, Tx_DV_out=0, Tx_Byte_out=0x00, Blk_Ready_out=1, Busy_out=0, Blk_Done_out=0, index=0, gap counter=0, Done edge register=0, and the payload register cleared.
REQ-027 A transmitter byte already in flight at reset SHALL NOT be counted after reset release.

Configuration
REQ-028 With macro UART_TX_HEADER_EN defined, each block SHALL be preceded by header byte 0xA5, sent with the same SEND/WAIT_DONE/GAP handshake, so that NUM_BYTES+1 strobes occur per block and Blk_Done_out fires only after the last payload byte.
REQ-029 Without UART_TX_HEADER_EN, no header logic SHALL exist and exactly NUM_BYTES strobes SHALL occur per block.

Structure
REQ-030 The state encoding localparams and the header constant 0xA5 SHALL reside in the shared package uart_ctrl_pkg.
REQ-031 The Tx_Done_in rising-edge detector SHALL be a sub-module named edge_detect_rise; the byte-select mux and counters SHALL remain inline.

Verification
REQ-032 Scenario 1: with NUM_BYTES=16, MSB_FIRST=1, and Blk_Data_in=0x00112233445566778899AABBCCDDEEFF paired with the real transmitter (CLKS_PER_BIT=8), Tx_Byte_out SHALL show 0x00, 0x11, …, 0xFF in order, followed by one Blk_Done_out pulse.
REQ-033 Scenario 2: with MSB_FIRST=0 and the same data, the first byte SHALL be 0xFF and the last byte 0x00.
REQ-034 Scenario 3: with Tx_Done_in held high for 2 clocks per byte, exactly 16 strobes SHALL occur and there SHALL be no double count.
REQ-035 Scenario 4: with GAP_CYCLES=5, the time from each Done rising edge to the next Tx_DV_out SHALL be at least 6 clocks, and Blk_Valid_in asserted mid-block SHALL be ignored.
REQ-036 Scenario 5: with RST_N pulsed low during byte 7, all outputs SHALL show their reset values within the reset clock, and a new block after release SHALL start at byte 0.
REQ-037 Scenario 6: with UART_TX_HEADER_EN defined, the first Tx_Byte_out SHALL be 0xA5, there SHALL be 17 strobes in total, and Blk_Done_out SHALL pulse once.
